// File: rtl/gpu_pkg.sv
// Shared constants for the scope display scan controller: raster timing,
// colour width, config address map, layer enable bits and reset colours.
package gpu_pkg;

    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 40;
    localparam int H_SYNC   = 128;
    localparam int H_BP     = 88;
    localparam int V_ACTIVE = 600;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 4;
    localparam int V_BP     = 23;

    localparam int COLOUR_W = 12;
    typedef logic [COLOUR_W-1:0] colour_t;

    typedef enum logic [1:0] {
        CFG_FRAME  = 2'd0,
        CFG_TRACE  = 2'd1,
        CFG_CURSOR = 2'd2,
        CFG_BG     = 2'd3
    } cfg_addr_e;

    localparam int EN_FRAME  = 0;
    localparam int EN_TRACE  = 1;
    localparam int EN_CURSOR = 2;

    localparam colour_t    RST_FRAME_COL  = 12'h555;
    localparam colour_t    RST_TRACE_COL  = 12'h0F0;
    localparam colour_t    RST_CURSOR_COL = 12'hFF0;
    localparam colour_t    RST_BG_COL     = 12'h000;
    localparam logic [2:0] RST_EN         = 3'b111;

endpackage

// File: rtl/gpu_scan_timing.sv
// Raster counters for the scan controller: row/col bus, visible-area flag,
// sync regions and the frame commit point (first blanking line, pixel 0).
module gpu_scan_timing
    import gpu_pkg::*;
#(
    parameter int P_H_ACTIVE = H_ACTIVE,
    parameter int P_H_FP     = H_FP,
    parameter int P_H_SYNC   = H_SYNC,
    parameter int P_H_BP     = H_BP,
    parameter int P_V_ACTIVE = V_ACTIVE,
    parameter int P_V_FP     = V_FP,
    parameter int P_V_SYNC   = V_SYNC,
    parameter int P_V_BP     = V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] o_row,
    output logic [9:0] o_col,
    output logic       o_in_active,
    output logic       o_hsync_region,
    output logic       o_vsync_region,
    output logic       o_commit
);

    localparam logic [10:0] H_ACT_END = 11'(P_H_ACTIVE);
    localparam logic [10:0] HS_START  = 11'(P_H_ACTIVE + P_H_FP);
    localparam logic [10:0] HS_END    = 11'(P_H_ACTIVE + P_H_FP + P_H_SYNC - 1);
    localparam logic [10:0] H_LAST    = 11'(P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP - 1);
    localparam logic [9:0]  V_ACT_END = 10'(P_V_ACTIVE);
    localparam logic [9:0]  VS_START  = 10'(P_V_ACTIVE + P_V_FP);
    localparam logic [9:0]  VS_END    = 10'(P_V_ACTIVE + P_V_FP + P_V_SYNC - 1);
    localparam logic [9:0]  V_LAST    = 10'(P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP - 1);

    logic [10:0] r_hcnt;
    logic [9:0]  r_vcnt;
    logic        r_run;

    // The first clock after reset release only arms r_run, so the raster
    // starts at 0,0 with everything quiet while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run  <= 1'b0;
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (!r_run) begin
            r_run <= 1'b1;
        end else if (r_hcnt == H_LAST) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == V_LAST) ? 10'd0 : r_vcnt + 10'd1;
        end else begin
            r_hcnt <= r_hcnt + 11'd1;
        end
    end

    assign o_row          = r_vcnt;
    assign o_col          = r_hcnt[9:0];
    assign o_in_active    = r_run && (r_hcnt < H_ACT_END) && (r_vcnt < V_ACT_END);
    assign o_hsync_region = r_run && (r_hcnt >= HS_START) && (r_hcnt <= HS_END);
    assign o_vsync_region = r_run && (r_vcnt >= VS_START) && (r_vcnt <= VS_END);
    assign o_commit       = r_run && (r_hcnt == 11'd0) && (r_vcnt == V_ACT_END);

endmodule

// File: rtl/gpu_scan_controller.sv
// Scan controller and layer mixer: drives row/col to the overlay layers,
// merges their hits by priority into a registered RGB444 pixel with syncs.
module gpu_scan_controller
    import gpu_pkg::*;
#(
    parameter int P_H_ACTIVE = H_ACTIVE,
    parameter int P_H_FP     = H_FP,
    parameter int P_H_SYNC   = H_SYNC,
    parameter int P_H_BP     = H_BP,
    parameter int P_V_ACTIVE = V_ACTIVE,
    parameter int P_V_FP     = V_FP,
    parameter int P_V_SYNC   = V_SYNC,
    parameter int P_V_BP     = V_BP
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [9:0]  row,
    output logic [9:0]  col,
    output logic        in_active,
    input  logic        frame_hit,
    input  logic        trace_hit,
    input  logic        cursor_hit,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_addr,
    input  logic [14:0] cfg_data,
    output logic [11:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start
);

    logic    w_in_active;
    logic    w_hs_region;
    logic    w_vs_region;
    logic    w_commit;
    logic    w_wr;
    colour_t w_pix;

    colour_t    r_sh_frame, r_sh_trace, r_sh_cursor, r_sh_bg;
    colour_t    r_act_frame, r_act_trace, r_act_cursor, r_act_bg;
    logic [2:0] r_sh_en, r_act_en;

    gpu_scan_timing #(
        .P_H_ACTIVE (P_H_ACTIVE),
        .P_H_FP     (P_H_FP),
        .P_H_SYNC   (P_H_SYNC),
        .P_H_BP     (P_H_BP),
        .P_V_ACTIVE (P_V_ACTIVE),
        .P_V_FP     (P_V_FP),
        .P_V_SYNC   (P_V_SYNC),
        .P_V_BP     (P_V_BP)
    ) u_timing (
        .clk            (clk),
        .rst_n          (rst_n),
        .o_row          (row),
        .o_col          (col),
        .o_in_active    (w_in_active),
        .o_hsync_region (w_hs_region),
        .o_vsync_region (w_vs_region),
        .o_commit       (w_commit)
    );

    assign in_active = w_in_active;
    // Blocking writes on the commit cycle keeps the shadow stable while it is copied.
    assign cfg_ready = ~w_commit;
    assign w_wr      = cfg_valid & cfg_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_frame   <= RST_FRAME_COL;
            r_sh_trace   <= RST_TRACE_COL;
            r_sh_cursor  <= RST_CURSOR_COL;
            r_sh_bg      <= RST_BG_COL;
            r_sh_en      <= RST_EN;
            r_act_frame  <= RST_FRAME_COL;
            r_act_trace  <= RST_TRACE_COL;
            r_act_cursor <= RST_CURSOR_COL;
            r_act_bg     <= RST_BG_COL;
            r_act_en     <= RST_EN;
        end else if (w_commit) begin
            r_act_frame  <= r_sh_frame;
            r_act_trace  <= r_sh_trace;
            r_act_cursor <= r_sh_cursor;
            r_act_bg     <= r_sh_bg;
            r_act_en     <= r_sh_en;
        end else if (w_wr) begin
            case (cfg_addr)
                CFG_FRAME:  r_sh_frame  <= cfg_data[COLOUR_W-1:0];
                CFG_TRACE:  r_sh_trace  <= cfg_data[COLOUR_W-1:0];
                CFG_CURSOR: r_sh_cursor <= cfg_data[COLOUR_W-1:0];
                default: begin
                    r_sh_bg <= cfg_data[COLOUR_W-1:0];
                    r_sh_en <= cfg_data[14:12];
                end
            endcase
        end
    end

    always_comb begin
        w_pix = '0;
        if (w_in_active) begin
            if (cursor_hit && r_act_en[EN_CURSOR]) begin
                w_pix = r_act_cursor;
            end else if (trace_hit && r_act_en[EN_TRACE]) begin
                w_pix = r_act_trace;
            end else if (frame_hit && r_act_en[EN_FRAME]) begin
                w_pix = r_act_frame;
            end else begin
                w_pix = r_act_bg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb         <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            rgb         <= w_pix;
            hsync       <= w_hs_region;
            vsync       <= w_vs_region;
            de          <= w_in_active;
            frame_start <= w_commit;
        end
    end

endmodule

// File: tb/tb_gpu_scan_controller.sv
// Bench for gpu_scan_controller on a shrunk raster (58x28) so several frames
// and commits fit in a short run; outputs are checked against a cycle-index model.
module tb_gpu_scan_controller;

    localparam int HA = 40, HFP = 4, HS = 8, HBP = 6;
    localparam int VA = 20, VFP = 1, VS = 4, VBP = 3;
    localparam int HT = HA + HFP + HS + HBP;   // 58
    localparam int VT = VA + VFP + VS + VBP;   // 28
    localparam int FT = HT * VT;               // 1624

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  row, col;
    logic        in_active;
    logic        frame_hit = 1'b0, trace_hit = 1'b0, cursor_hit = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_addr = 2'd0;
    logic [14:0] cfg_data = '0;
    logic [11:0] rgb;
    logic        hsync, vsync, de, frame_start;

    int n_tests = 0;
    int n_fail  = 0;
    bit done    = 0;

    gpu_scan_controller #(
        .P_H_ACTIVE (HA), .P_H_FP (HFP), .P_H_SYNC (HS), .P_H_BP (HBP),
        .P_V_ACTIVE (VA), .P_V_FP (VFP), .P_V_SYNC (VS), .P_V_BP (VBP)
    ) dut (
        .clk (clk), .rst_n (rst_n), .row (row), .col (col), .in_active (in_active),
        .frame_hit (frame_hit), .trace_hit (trace_hit), .cursor_hit (cursor_hit),
        .cfg_valid (cfg_valid), .cfg_ready (cfg_ready), .cfg_addr (cfg_addr),
        .cfg_data (cfg_data), .rgb (rgb), .hsync (hsync), .vsync (vsync),
        .de (de), .frame_start (frame_start)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: m_cyc counts clock edges since reset release. Edge 1 starts the
    // raster at 0,0, so cycle index c >= 1 sits at raster position (c-1) mod FT.
    int         m_cyc;
    logic [11:0] sh_col [4];
    logic [11:0] ac_col [4];
    logic [2:0]  sh_en, ac_en;
    logic [11:0] exp_rgb;
    bit          exp_hs, exp_vs, exp_de, exp_fs;

    function automatic bit run_of(input int c);  return c >= 1; endfunction
    function automatic int h_of(input int c);    return run_of(c) ? ((c - 1) % FT) % HT : 0; endfunction
    function automatic int v_of(input int c);    return run_of(c) ? ((c - 1) % FT) / HT : 0; endfunction
    function automatic bit act_of(input int c);  return run_of(c) && h_of(c) < HA && v_of(c) < VA; endfunction
    function automatic bit com_of(input int c);  return run_of(c) && h_of(c) == 0 && v_of(c) == VA; endfunction

    function automatic logic [11:0] mix_of(input int c);
        if (!act_of(c))                    return 12'h000;
        if (cursor_hit && ac_en[2])        return ac_col[2];
        if (trace_hit && ac_en[1])         return ac_col[1];
        if (frame_hit && ac_en[0])         return ac_col[0];
        return ac_col[3];
    endfunction

    task automatic model_reset();
        m_cyc = 0;
        sh_col[0] = 12'h555; sh_col[1] = 12'h0F0; sh_col[2] = 12'hFF0; sh_col[3] = 12'h000;
        ac_col = sh_col;
        sh_en = 3'b111; ac_en = 3'b111;
        exp_rgb = 12'h000; exp_hs = 0; exp_vs = 0; exp_de = 0; exp_fs = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                exp_rgb = mix_of(m_cyc);
                exp_de  = act_of(m_cyc);
                exp_hs  = run_of(m_cyc) && h_of(m_cyc) >= HA + HFP && h_of(m_cyc) < HA + HFP + HS;
                exp_vs  = run_of(m_cyc) && v_of(m_cyc) >= VA + VFP && v_of(m_cyc) < VA + VFP + VS;
                exp_fs  = com_of(m_cyc);
                if (com_of(m_cyc)) begin
                    ac_col = sh_col;
                    ac_en  = sh_en;
                end else if (cfg_valid) begin
                    sh_col[cfg_addr] = cfg_data[11:0];
                    if (cfg_addr == 2'd3) sh_en = cfg_data[14:12];
                end
                m_cyc++;
            end
        end
    end

    // Compare process: every cycle, plus period/width checks of the syncs.
    initial begin
        int cc = 0, hs_rise = -1, hs_prev_rise = -1, vs_rise = -1, fs_prev = -1;
        bit hs_q = 0, vs_q = 0;
        while (!done) begin
            @(negedge clk);
            cc++;
            chk("rgb", rgb, exp_rgb);
            chk("hsync", hsync, exp_hs);
            chk("vsync", vsync, exp_vs);
            chk("de", de, exp_de);
            chk("frame_start", frame_start, exp_fs);
            chk("in_active", in_active, act_of(m_cyc));
            chk("cfg_ready", cfg_ready, !com_of(m_cyc));
            if (act_of(m_cyc) || !run_of(m_cyc)) begin
                chk("row", row, v_of(m_cyc));
                chk("col", col, h_of(m_cyc));
            end
            if (!rst_n) begin
                hs_rise = -1; hs_prev_rise = -1; vs_rise = -1; fs_prev = -1;
                hs_q = 0; vs_q = 0;
            end else begin
                if (hsync && !hs_q) begin
                    if (hs_prev_rise >= 0) chk("hsync_period", cc - hs_prev_rise, 58);
                    hs_prev_rise = cc;
                    hs_rise = cc;
                end
                if (!hsync && hs_q && hs_rise >= 0) chk("hsync_width", cc - hs_rise, 8);
                if (vsync && !vs_q) vs_rise = cc;
                if (!vsync && vs_q && vs_rise >= 0) chk("vsync_width", cc - vs_rise, 232);
                if (frame_start) begin
                    if (fs_prev >= 0) chk("frame_start_period", cc - fs_prev, 1624);
                    fs_prev = cc;
                end
                hs_q = hsync;
                vs_q = vsync;
            end
        end
    end

    task automatic rand_hits();
        frame_hit  = 1'($urandom);
        trace_hit  = 1'($urandom);
        cursor_hit = 1'($urandom);
    endtask

    // Advance (from a negedge) until the model's current raster position is (th, tv).
    task automatic goto(input int th, input int tv);
        for (int k = 0; k < 2 * FT; k++) begin
            if (run_of(m_cyc) && h_of(m_cyc) == th && v_of(m_cyc) == tv) return;
            rand_hits();
            cfg_valid = 1'b0;
            @(negedge clk);
        end
        n_tests++;
        n_fail++;
        $display("FAIL goto_timeout: position %0d,%0d not reached, expected within %0d cycles", th, tv, 2 * FT);
    endtask

    task automatic set_hits(input bit f, input bit t, input bit c);
        frame_hit = f; trace_hit = t; cursor_hit = c;
    endtask

    task automatic rand_run(input int n);
        for (int k = 0; k < n; k++) begin
            rand_hits();
            cfg_valid = ($urandom_range(0, 15) == 0);
            cfg_addr  = 2'($urandom);
            cfg_data  = 15'($urandom);
            @(negedge clk);
        end
        cfg_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rgb"}, rgb, 0);
        chk({tag, "_hsync"}, hsync, 0);
        chk({tag, "_vsync"}, vsync, 0);
        chk({tag, "_de"}, de, 0);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_cfg_ready"}, cfg_ready, 1);
        chk({tag, "_row"}, row, 0);
        chk({tag, "_col"}, col, 0);
        chk({tag, "_in_active"}, in_active, 0);
    endtask

    // Release reset and count edges to the first de and first hsync.
    task automatic release_and_measure(input string tag);
        int n_de = -1, n_hs = -1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int n = 1; n <= 200 && (n_de < 0 || n_hs < 0); n++) begin
            @(posedge clk);
            #1;
            if (de && n_de < 0) n_de = n;
            if (hsync && n_hs < 0) n_hs = n;
        end
        chk({tag, "_first_de_edge"}, n_de, 2);
        chk({tag, "_first_hsync_edge"}, n_hs, HA + HFP + 2);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 check_reset_values("por");
        release_and_measure("por");

        // trace beats frame with reset colours
        goto(25, 10);
        set_hits(1, 1, 0);
        @(negedge clk);
        chk("trace_over_frame", rgb, 12'h0F0);

        // disable trace; visible only after the next commit
        goto(0, 2);
        cfg_valid = 1'b1; cfg_addr = 2'd3; cfg_data = 15'h5000;
        @(negedge clk);
        cfg_valid = 1'b0;
        goto(25, 10);
        set_hits(1, 1, 0);
        @(negedge clk);
        chk("trace_disable_pending", rgb, 12'h0F0);
        goto(25, 10);
        set_hits(1, 1, 0);
        @(negedge clk);
        chk("trace_disabled", rgb, 12'h555);

        // frame colour change held off until the commit
        goto(3, 5);
        cfg_valid = 1'b1; cfg_addr = 2'd0; cfg_data = 15'h0F00;
        @(negedge clk);
        cfg_valid = 1'b0;
        goto(25, 10);
        set_hits(1, 0, 0);
        @(negedge clk);
        chk("frame_col_pending", rgb, 12'h555);
        goto(VA - 1 == 19 ? 39 : 0, 19);
        set_hits(1, 0, 0);
        @(negedge clk);
        chk("frame_col_last_row", rgb, 12'h555);
        goto(0, 20);
        chk("commit_ready_low", cfg_ready, 0);
        @(negedge clk);
        chk("commit_ready_back", cfg_ready, 1);
        chk("commit_frame_start", frame_start, 1);
        goto(25, 10);
        set_hits(1, 0, 0);
        @(negedge clk);
        chk("frame_col_applied", rgb, 12'hF00);

        // valid held across the commit: before -> this commit, during -> dropped, after -> next
        goto(HT - 2, 19);
        cfg_valid = 1'b1; cfg_addr = 2'd3; cfg_data = 15'h7000;
        @(negedge clk);
        cfg_addr = 2'd1; cfg_data = 15'h000A;
        @(negedge clk);
        chk("held_commit_ready_low", cfg_ready, 0);
        cfg_data = 15'h000B;
        @(negedge clk);
        cfg_data = 15'h000C;
        @(negedge clk);
        cfg_valid = 1'b0;
        goto(25, 10);
        set_hits(0, 1, 0);
        @(negedge clk);
        chk("held_before_commit", rgb, 12'h00A);
        goto(25, 10);
        set_hits(0, 1, 0);
        @(negedge clk);
        chk("held_after_commit", rgb, 12'h00C);
        set_hits(1, 1, 1);
        goto(25, 11);
        set_hits(0, 0, 1);
        @(negedge clk);
        chk("cursor_priority", rgb, 12'hFF0);

        rand_run(4 * FT);

        // mid-frame reset, with an uncommitted shadow write outstanding
        goto(20, 12);
        cfg_valid = 1'b1; cfg_addr = 2'd2; cfg_data = 15'h0123;
        @(negedge clk);
        cfg_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        repeat (2) @(negedge clk);
        release_and_measure("midrst");
        goto(25, 10);
        set_hits(0, 0, 1);
        @(negedge clk);
        chk("midrst_cursor_default", rgb, 12'hFF0);
        goto(25, 10);
        set_hits(0, 0, 1);
        @(negedge clk);
        chk("midrst_shadow_lost", rgb, 12'hFF0);

        rand_run(2 * FT);

        done = 1;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
